// File: rtl/btc_miner_dispatch.sv
// btc_miner_dispatch: launches N mining cores, collects their nonce hits through
// per-core pending slots and a round-robin arbiter into a first-word-fall-through FIFO.
module btc_miner_dispatch #(
  parameter int NUM_CORES = 4,
  parameter int FIFO_DEPTH = 8,
  localparam int CORE_ID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     config_oneshot,
  output logic                     core_start,
  output logic                     core_abort,
  input  logic [NUM_CORES-1:0]     core_found,
  input  logic [32*NUM_CORES-1:0] core_nonce,
  input  logic [NUM_CORES-1:0]     core_done,
  output logic                     res_valid,
  output logic [31:0]              res_nonce,
  output logic [CORE_ID_W-1:0]     res_core,
  input  logic                     res_pop,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              hit_count,
  output logic                     overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_ABORT, S_DONE} state_t;
  state_t r_state, w_next;
  logic r_oneshot, r_from_abort, r_overflow;
  logic [NUM_CORES-1:0] r_full, r_done_lat, w_gi, w_load;
  logic [31:0] r_slot [NUM_CORES];
  logic [CORE_ID_W-1:0] r_ptr, w_gnt;
  logic [15:0] r_hits;
  logic [31:0] r_mem_n [FIFO_DEPTH];
  logic [CORE_ID_W-1:0] r_mem_c [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  logic w_any, w_push, w_pop, w_fifo_full, w_run, w_launch, w_drop, w_all_done;

  function automatic int wrap(input int v);
    return (v >= NUM_CORES) ? v - NUM_CORES : v;
  endfunction

  assign w_run = (r_state == S_RUN);
  assign w_launch = (r_state == S_LAUNCH);
  assign w_fifo_full = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_push = w_run & w_any & ~w_fifo_full;
  assign w_pop = res_pop & (r_cnt != '0);
  assign w_gi = NUM_CORES'(w_push) << w_gnt;
  // A granted slot may reload in the same cycle, so it never counts as a drop.
  assign w_load = core_found & (~r_full | w_gi) & {NUM_CORES{w_run}};
  assign w_drop = w_run & |(core_found & r_full & ~w_gi);
  assign w_all_done = (&r_done_lat) & ~(|r_full);

  always_comb begin : p_arb
    logic [CORE_ID_W-1:0] idx;
    w_any = 1'b0;
    w_gnt = '0;
    idx = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      idx = CORE_ID_W'(wrap(int'(r_ptr) + k));
      if (r_full[idx]) begin
        w_any = 1'b1;
        w_gnt = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) r_state <= S_IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = start ? S_LAUNCH : S_IDLE;
      S_LAUNCH: w_next = S_RUN;
      S_RUN:    w_next = (stop || (r_oneshot && w_push)) ? S_ABORT : w_all_done ? S_DONE : S_RUN;
      S_ABORT:  w_next = S_DONE;
      S_DONE:   w_next = start ? S_LAUNCH : S_DONE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    core_start = w_launch;
    core_abort = (r_state == S_ABORT) | ((r_state == S_DONE) & r_from_abort);
    busy = w_launch | w_run;
    done = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_full <= '0;
      r_done_lat <= '0;
      r_ptr <= '0;
      r_hits <= '0;
      r_overflow <= 1'b0;
      r_oneshot <= 1'b0;
      r_from_abort <= 1'b0;
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else if (w_launch) begin
      r_full <= '0;
      r_done_lat <= '0;
      r_ptr <= '0;
      r_hits <= '0;
      r_overflow <= 1'b0;
      r_oneshot <= config_oneshot;
      r_from_abort <= 1'b0;
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      r_full <= (r_state == S_ABORT) ? '0 : (r_full & ~w_gi) | w_load;
      r_done_lat <= w_run ? (r_done_lat | core_done) : r_done_lat;
      r_ptr <= w_push ? CORE_ID_W'(wrap(int'(w_gnt) + 1)) : r_ptr;
      r_hits <= (w_push && r_hits != 16'hFFFF) ? r_hits + 16'd1 : r_hits;
      r_overflow <= r_overflow | w_drop;
      r_from_abort <= r_from_abort | (r_state == S_ABORT);
      r_wr <= r_wr + AW'(w_push);
      r_rd <= r_rd + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++)
      if (w_load[i]) r_slot[i] <= core_nonce[32*i +: 32];
    if (w_push) begin
      r_mem_n[r_wr] <= r_slot[w_gnt];
      r_mem_c[r_wr] <= w_gnt;
    end
  end

  assign res_valid = (r_cnt != '0);
  assign res_nonce = res_valid ? r_mem_n[r_rd] : '0;
  assign res_core = res_valid ? r_mem_c[r_rd] : '0;
  assign hit_count = r_hits;
  assign overflow = r_overflow;
endmodule
